// File: rtl/branch_pred_ctrl_pkg.sv
// Shared types and constants for the branch-prediction controller and its BHT.
// Counter encoding: SNT/WNT predict not-taken, WT/ST predict taken (bit 1 is the prediction).
package branch_pred_ctrl_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam int IDX_W_DEF = 4;

endpackage

// File: rtl/branch_pred_ctrl_bht.sv
// 2^IDX_W x 2-bit branch history table: asynchronous read, one synchronous write port.
// The write is either a clear-sweep store or a saturating counter update.
module bht_table
  import branch_pred_ctrl_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_cnt,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx,
  input  logic [1:0]       clr_val,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0] mem_q [DEPTH];
  logic [1:0] mem_d [DEPTH];

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == ST) ? ST : cnt + 2'd1;
    return (cnt == SNT) ? SNT : cnt - 2'd1;
  endfunction

  // Read sees the pre-edge value, so a same-index write shows up the next cycle.
  assign rd_cnt = mem_q[rd_idx];

  always_comb begin
    mem_d = mem_q;
    if (clr_en) begin
      mem_d[clr_idx] = clr_val;
    end else if (upd_en) begin
      mem_d[upd_idx] = sat_update(mem_q[upd_idx], upd_taken);
    end
  end

  // No reset: contents are defined by the clear sweep.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/branch_pred_ctrl.sv
// Branch-prediction controller: BHT+BTB next-PC steering, EX misprediction redirect,
// BTB write scheduling, post-reset BHT clear sweep and saturating statistics.
module branch_pred_ctrl
  import branch_pred_ctrl_pkg::*;
#(
  parameter int         IDX_W    = IDX_W_DEF,
  parameter int         CNT_W    = 16,
  parameter logic [1:0] BHT_INIT = WNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      PCF,
  input  logic             btb_hit,
  input  logic [31:0]      btb_target,
  input  logic             ex_valid,
  input  logic             ex_is_br,
  input  logic [31:0]      ex_pc,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pred_pc,
  output logic             pred_taken,
  output logic [31:0]      pred_pc,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic             btb_upd,
  output logic [31:0]      btb_upd_pc,
  output logic [31:0]      btb_upd_target,
  output logic             init_busy,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic             state_dbg
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0]   mis_cnt_q, mis_cnt_d;
  logic               run;
  logic               ex_br;
  logic [31:0]        cnpc;
  logic [1:0]         rd_cnt;
  logic               unused_pred_taken;

  // The carried direction is redundant: the PC compare already covers it.
  assign unused_pred_taken = ex_pred_taken;

  bht_table #(.IDX_W(IDX_W)) u_bht (
    .clk       (clk),
    .rd_idx    (PCF[IDX_W+1:2]),
    .rd_cnt    (rd_cnt),
    .clr_en    (!run),
    .clr_idx   (idx_q),
    .clr_val   (BHT_INIT),
    .upd_en    (run && ex_br),
    .upd_idx   (ex_pc[IDX_W+1:2]),
    .upd_taken (ex_taken)
  );

  always_comb begin
    run            = (state_q == ST_RUN);
    ex_br          = ex_valid && ex_is_br;
    cnpc           = ex_taken ? ex_target : ex_pc + 32'd4;

    pred_taken     = run && btb_hit && rd_cnt[1];
    pred_pc        = pred_taken ? btb_target : PCF + 32'd4;
    redirect       = run && ex_br && (ex_pred_pc != cnpc);
    redirect_pc    = cnpc;
    flush          = redirect;
    btb_upd        = run && ex_br && ex_taken;
    btb_upd_pc     = ex_pc;
    btb_upd_target = ex_target;
    init_busy      = !run;
    br_cnt         = br_cnt_q;
    mispred_cnt    = mis_cnt_q;
    state_dbg      = state_q;

    state_d   = state_q;
    idx_d     = idx_q;
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;

    if (!run) begin
      idx_d = idx_q + IDX_W'(1);
      if (&idx_q) state_d = ST_RUN;
    end else if (ex_br) begin
      if (br_cnt_q != '1) br_cnt_d = br_cnt_q + CNT_W'(1);
      if (redirect && (mis_cnt_q != '1)) mis_cnt_d = mis_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_CLEAR;
      idx_q     <= '0;
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

endmodule
